// File: rtl/riscv_thread_scheduler.sv
// Barrel-thread issue scheduler: per-thread PC/active/in-flight state, one registered (tid, pc) fetch slot per cycle.
// Fixed rotation or skip-idle round-robin selection over ready threads.
module riscv_thread_scheduler #(
  parameter int unsigned              NUM_THREADS  = 32,
  parameter int unsigned              PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]      STARTUP_ADDR = '0,
  parameter int unsigned              SKIP_IDLE    = 0,
  parameter int unsigned              RESET_ACTIVE = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           run,
  input  logic                           start_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] start_tid,
  input  logic [PC_WIDTH-1:0]            start_pc,
  input  logic                           stop_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] stop_tid,
  input  logic                           redirect_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] redirect_tid,
  input  logic [PC_WIDTH-1:0]            redirect_pc,
  output logic                           issue_valid,
  output logic [$clog2(NUM_THREADS)-1:0] issue_tid,
  output logic [PC_WIDTH-1:0]            issue_pc,
  output logic [NUM_THREADS-1:0]         active_mask,
  output logic                           protocol_err
);

  localparam int unsigned TW = $clog2(NUM_THREADS);
  localparam logic [NUM_THREADS-1:0] ACTIVE_INIT =
    (RESET_ACTIVE != 0) ? '1 : NUM_THREADS'(1);

  logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
  logic [NUM_THREADS-1:0] active_q;
  logic [NUM_THREADS-1:0] in_flight_q;
  logic [NUM_THREADS-1:0] ready;
  logic [TW-1:0]          ptr_q;
  logic [TW-1:0]          ptr_next;
  logic [TW-1:0]          sel_tid;
  logic [TW-1:0]          cand;
  logic                   sel_valid;
  logic                   start_ok;

  assign ready       = active_q & ~in_flight_q;
  assign active_mask = active_q;

  always_comb begin
    sel_valid = 1'b0;
    sel_tid   = ptr_q;
    ptr_next  = ptr_q;
    cand      = '0;
    if (run) begin
      if (SKIP_IDLE != 0) begin
        // First ready thread at or after ptr; TW-bit addition gives the wrap for free.
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
          cand = ptr_q + TW'(i);
          if (!sel_valid && ready[cand]) begin
            sel_valid = 1'b1;
            sel_tid   = cand;
          end
        end
        if (sel_valid) ptr_next = sel_tid + TW'(1);
      end else begin
        sel_valid = ready[ptr_q];
        ptr_next  = ptr_q + TW'(1);
      end
    end
  end

  // A start loses to a stop or a redirect naming the same thread.
  assign start_ok = start_valid && !active_q[start_tid] && !in_flight_q[start_tid] &&
                    !(stop_valid && stop_tid == start_tid) &&
                    !(redirect_valid && redirect_tid == start_tid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) pc_q[t] <= STARTUP_ADDR;
      active_q     <= ACTIVE_INIT;
      in_flight_q  <= '0;
      ptr_q        <= '0;
      issue_valid  <= 1'b0;
      issue_tid    <= '0;
      issue_pc     <= '0;
      protocol_err <= 1'b0;
    end else begin
      ptr_q       <= ptr_next;
      issue_valid <= sel_valid;
      if (run) issue_tid <= sel_tid;
      if (sel_valid) begin
        issue_pc             <= pc_q[sel_tid];
        in_flight_q[sel_tid] <= 1'b1;
      end
      // An in-flight thread is never ready, so this cannot collide with the issue above.
      if (redirect_valid) begin
        if (in_flight_q[redirect_tid]) begin
          pc_q[redirect_tid]        <= redirect_pc;
          in_flight_q[redirect_tid] <= 1'b0;
        end else begin
          protocol_err <= 1'b1;
        end
      end
      if (start_ok) begin
        active_q[start_tid] <= 1'b1;
        pc_q[start_tid]     <= start_pc;
      end
      if (stop_valid) active_q[stop_tid] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_thread_scheduler.sv
// Self-checking bench: one fixed-rotation instance (all threads active) and one skip-idle instance (thread 0 only).
module tb_riscv_thread_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        f_run, f_st_v, f_sp_v, f_rd_v;
  logic [4:0]  f_st_tid, f_sp_tid, f_rd_tid, f_tid;
  logic [31:0] f_st_pc, f_rd_pc, f_pc, f_mask;
  logic        f_valid, f_err;

  logic        s_run, s_st_v, s_sp_v, s_rd_v;
  logic [4:0]  s_st_tid, s_sp_tid, s_rd_tid, s_tid;
  logic [31:0] s_st_pc, s_rd_pc, s_pc, s_mask;
  logic        s_valid, s_err;

  riscv_thread_scheduler #(.NUM_THREADS(32), .PC_WIDTH(32), .STARTUP_ADDR(32'h0),
                           .SKIP_IDLE(0), .RESET_ACTIVE(1)) u_fix (
    .clk(clk), .reset_n(reset_n), .run(f_run),
    .start_valid(f_st_v), .start_tid(f_st_tid), .start_pc(f_st_pc),
    .stop_valid(f_sp_v), .stop_tid(f_sp_tid),
    .redirect_valid(f_rd_v), .redirect_tid(f_rd_tid), .redirect_pc(f_rd_pc),
    .issue_valid(f_valid), .issue_tid(f_tid), .issue_pc(f_pc),
    .active_mask(f_mask), .protocol_err(f_err));

  riscv_thread_scheduler #(.NUM_THREADS(32), .PC_WIDTH(32), .STARTUP_ADDR(32'h0),
                           .SKIP_IDLE(1), .RESET_ACTIVE(0)) u_skip (
    .clk(clk), .reset_n(reset_n), .run(s_run),
    .start_valid(s_st_v), .start_tid(s_st_tid), .start_pc(s_st_pc),
    .stop_valid(s_sp_v), .stop_tid(s_sp_tid),
    .redirect_valid(s_rd_v), .redirect_tid(s_rd_tid), .redirect_pc(s_rd_pc),
    .issue_valid(s_valid), .issue_tid(s_tid), .issue_pc(s_pc),
    .active_mask(s_mask), .protocol_err(s_err));

  typedef struct {
    logic        run;
    logic        st_v;  logic [4:0] st_tid; logic [31:0] st_pc;
    logic        sp_v;  logic [4:0] sp_tid;
    logic        rd_v;  logic [4:0] rd_tid; logic [31:0] rd_pc;
    logic        e_v;   logic [4:0] e_tid;  logic [31:0] e_pc;
    logic [31:0] e_mask;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [4:0]  tid;
    logic [31:0] pc;
    int          due;
  } rd_t;

  vec_t tbl[$];
  rd_t  rq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic vec_t mk(logic run, logic st_v, logic [4:0] st_tid, logic [31:0] st_pc,
                              logic sp_v, logic [4:0] sp_tid,
                              logic rd_v, logic [4:0] rd_tid, logic [31:0] rd_pc,
                              logic e_v, logic [4:0] e_tid, logic [31:0] e_pc,
                              logic [31:0] e_mask, logic e_err);
    vec_t v;
    v.run = run; v.st_v = st_v; v.st_tid = st_tid; v.st_pc = st_pc;
    v.sp_v = sp_v; v.sp_tid = sp_tid;
    v.rd_v = rd_v; v.rd_tid = rd_tid; v.rd_pc = rd_pc;
    v.e_v = e_v; v.e_tid = e_tid; v.e_pc = e_pc; v.e_mask = e_mask; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  initial begin
    f_run = 0; f_st_v = 0; f_st_tid = 0; f_st_pc = 0; f_sp_v = 0; f_sp_tid = 0;
    f_rd_v = 0; f_rd_tid = 0; f_rd_pc = 0;
    s_run = 0; s_st_v = 0; s_st_tid = 0; s_st_pc = 0; s_sp_v = 0; s_sp_tid = 0;
    s_rd_v = 0; s_rd_tid = 0; s_rd_pc = 0;

    // Skip-idle scenario: rows applied one per cycle, expectations sampled after the edge.
    tbl.push_back(mk(0, 0,  0, 32'h000, 1, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 1,  3, 32'h100, 0, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h0000_0008, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 1,  3, 32'h100, 32'h0000_0008, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h0000_0008, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 1,  3, 32'h104, 0,  0, 32'h000, 32'h0000_0008, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 1,  3, 32'h104, 32'h0000_0008, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h0000_0008, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 1,  3, 32'h108, 0,  0, 32'h000, 32'h0000_0008, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 1,  3, 32'h108, 32'h0000_0008, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 1, 3, 1,  3, 32'h10c, 0,  0, 32'h000, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 1, 30, 32'h300, 0, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h4000_0000, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 1, 30, 32'h300, 32'h4000_0000, 0));
    tbl.push_back(mk(0, 1,  1, 32'h200, 0, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h4000_0002, 0));
    tbl.push_back(mk(0, 0,  0, 32'h000, 0, 0, 1, 30, 32'h304, 0,  0, 32'h000, 32'h4000_0002, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 1,  1, 32'h200, 32'h4000_0002, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 1, 30, 32'h304, 32'h4000_0002, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h4000_0002, 0));
    tbl.push_back(mk(0, 1,  5, 32'h500, 1, 5, 0,  0, 32'h000, 0,  0, 32'h000, 32'h4000_0002, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h4000_0002, 0));
    tbl.push_back(mk(0, 1,  1, 32'h999, 0, 0, 1,  1, 32'h204, 0,  0, 32'h000, 32'h4000_0002, 0));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 1,  1, 32'h204, 32'h4000_0002, 0));
    tbl.push_back(mk(0, 0,  0, 32'h000, 0, 0, 1,  7, 32'h777, 0,  0, 32'h000, 32'h4000_0002, 1));
    tbl.push_back(mk(1, 0,  0, 32'h000, 0, 0, 0,  0, 32'h000, 0,  0, 32'h000, 32'h4000_0002, 1));

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_valid", 64'(f_valid), 64'(0));
    chk("rst_f_tid",   64'(f_tid),   64'(0));
    chk("rst_f_pc",    64'(f_pc),    64'(0));
    chk("rst_f_mask",  64'(f_mask),  64'(32'hFFFF_FFFF));
    chk("rst_f_err",   64'(f_err),   64'(0));
    chk("rst_s_mask",  64'(s_mask),  64'(32'h0000_0001));
    chk("rst_s_valid", 64'(s_valid), 64'(0));
    reset_n = 1'b1;

    foreach (tbl[r]) begin
      s_run = tbl[r].run;
      s_st_v = tbl[r].st_v; s_st_tid = tbl[r].st_tid; s_st_pc = tbl[r].st_pc;
      s_sp_v = tbl[r].sp_v; s_sp_tid = tbl[r].sp_tid;
      s_rd_v = tbl[r].rd_v; s_rd_tid = tbl[r].rd_tid; s_rd_pc = tbl[r].rd_pc;
      @(posedge clk);
      #1;
      chk($sformatf("skip_valid[%0d]", r), 64'(s_valid), 64'(tbl[r].e_v));
      if (tbl[r].e_v) begin
        chk($sformatf("skip_tid[%0d]", r), 64'(s_tid), 64'(tbl[r].e_tid));
        chk($sformatf("skip_pc[%0d]", r),  64'(s_pc),  64'(tbl[r].e_pc));
      end
      chk($sformatf("skip_mask[%0d]", r), 64'(s_mask), 64'(tbl[r].e_mask));
      chk($sformatf("skip_err[%0d]", r),  64'(s_err),  64'(tbl[r].e_err));
    end
    s_run = 0; s_st_v = 0; s_sp_v = 0; s_rd_v = 0;

    // Fixed mode: stray redirect to tid 7 before anything issues
    f_rd_v = 1; f_rd_tid = 7; f_rd_pc = 32'h777;
    @(posedge clk);
    #1;
    chk("fix_err_set",   64'(f_err),   64'(1));
    chk("fix_err_noiss", 64'(f_valid), 64'(0));
    f_rd_v = 0;

    // Fixed rotation with a redirect responder (pc+4, 10 cycles after issue); tid 5 stopped mid-run
    for (int c = 0; c < 100; c++) begin
      logic exp_v;
      f_run = 1;
      f_rd_v = 0;
      if (rq.size() > 0 && rq[0].due == c) begin
        f_rd_v = 1; f_rd_tid = rq[0].tid; f_rd_pc = rq[0].pc;
        void'(rq.pop_front());
      end
      f_sp_v = (c == 66); f_sp_tid = 5;
      @(posedge clk);
      #1;
      exp_v = !(c >= 64 && (c % 32) == 5);
      chk($sformatf("fix_valid[%0d]", c), 64'(f_valid), 64'(exp_v));
      if (exp_v) begin
        chk($sformatf("fix_tid[%0d]", c), 64'(f_tid), 64'(c % 32));
        chk($sformatf("fix_pc[%0d]", c),  64'(f_pc),  64'(4 * (c / 32)));
      end
      if (c == 70) chk("fix_mask_stop5", 64'(f_mask), 64'(32'hFFFF_FFDF));
      if (f_valid) rq.push_back('{tid: f_tid, pc: f_pc + 32'd4, due: c + 10});
    end
    chk("fix_err_sticky", 64'(f_err), 64'(1));
    chk("fix_inflight_before_rst", 64'(rq.size()), 64'(10));

    // Asynchronous reset mid-stream
    #3;
    reset_n = 1'b0;
    f_rd_v = 0; f_sp_v = 0;
    rq.delete();
    #1;
    chk("mid_rst_valid", 64'(f_valid), 64'(0));
    chk("mid_rst_tid",   64'(f_tid),   64'(0));
    chk("mid_rst_pc",    64'(f_pc),    64'(0));
    chk("mid_rst_err",   64'(f_err),   64'(0));
    chk("mid_rst_mask",  64'(f_mask),  64'(32'hFFFF_FFFF));
    chk("mid_rst_serr",  64'(s_err),   64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_valid[%0d]", c), 64'(f_valid), 64'(1));
      chk($sformatf("post_rst_tid[%0d]", c),   64'(f_tid),   64'(c));
      chk($sformatf("post_rst_pc[%0d]", c),    64'(f_pc),    64'(0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
